small_divider: RTL and testbench
================================

Name: small_divider

Overview:
- Sequential restoring divider. Inverse of the display path's small-constant multiply: recovers a value and its remainder from a scaled display coordinate.
- Divides a WIDTH+1-bit unsigned dividend by a 2-bit divisor (1..3) at one quotient bit per clock.
- Start/done handshake. Sits between display address generation and the coordinate-to-cell lookup.

Parameters:
WIDTH, 8, base value width; dividend and quotient are WIDTH+1 bits

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH+1  unsigned dividend, captured on the accepting edge
divisor  input  2  unsigned divisor, captured on the accepting edge
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH+1  registered quotient
remainder  output  2  registered remainder
div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset: asynchronous on reset_n low, released synchronously to clk by the surrounding logic.
  - State -> IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal shift/accumulator registers cleared.
- Reset mid-operation: abort immediately. No done pulse follows. The first start after release begins a fresh operation.
- States: IDLE, CALC, FINISH.
- IDLE:
  - start=1 at edge E0 captures dividend and divisor.
  - If divisor!=0: go to CALC; load bit counter with WIDTH+1; partial remainder=0.
  - If divisor==0: go straight to FINISH with quotient = all ones, remainder=0, div_by_zero=1.
- CALC: at each of edges E1..E(WIDTH+1), one restoring step, MSB first:
  - Partial remainder (3 bits) = {rem[1:0], next dividend bit}.
  - If partial >= divisor: subtract divisor and shift in quotient bit 1; else shift in 0.
  - Counter decrements each step.
  - At E(WIDTH+1): quotient and remainder output registers updated, div_by_zero=0, go to FINISH.
- FINISH: lasts exactly one cycle with done=1, then IDLE at the next edge.
- busy: 1 in CALC and FINISH, 0 in IDLE.
- Latency, divisor!=0: done is high in the cycle after E(WIDTH+1), i.e. WIDTH+1 cycles after the accepting edge.
- Latency, divisor==0: done is high in the cycle after E0.
- Back-to-back: start is ignored in CALC and FINISH, with no queuing. Earliest new accept is the edge after FINISH (IDLE with start=1).
- Hold: quotient, remainder and div_by_zero hold their values until the next operation completes. They do not change during CALC.
- Input stability: dividend and divisor may change freely after E0; only the captured copies are used.
- Widths:
  - Remainder is always < divisor, so it fits in 2 bits.
  - Partial remainder needs 3 bits (max 2*2+1=5).
  - No arithmetic overflow is possible.
- No combinational path from inputs to outputs.

Test Plan:
- reset_n low then high; dividend=9'd510, divisor=2, start for one cycle -> busy next cycle; done exactly 9 cycles after accept; quotient=255, remainder=0, div_by_zero=0.
- dividend=511, divisor=3 -> quotient=170, remainder=1. Then dividend=0, divisor=1 -> quotient=0, remainder=0. Results hold stable until the next done.
- dividend=7, divisor=0 -> done one cycle after accept; quotient=9'h1FF, remainder=0, div_by_zero=1. A following 9/3 operation -> quotient=3, remainder=0, div_by_zero cleared.
- Start 500/2; pulse start again with 9/3 in cycles 3 and 9 (CALC and FINISH) -> ignored; result 250 r0. Start held high continuously -> new operation accepted only on the edge after FINISH.
- Start 300/3; assert reset_n low in cycle 4 -> all outputs 0 asynchronously, no done pulse. After release, 10/3 -> quotient=3, remainder=1.
- Random sweep: all 512 dividends x divisors 1..3 -> quotient/remainder match integer division; done is always one cycle wide.

Source files
------------

// File: rtl/small_divider.sv
// small_divider: sequential restoring divider that recovers a base value and
// its remainder from a display coordinate scaled by a small constant (1..3).
// Produces one quotient bit per clock, MSB first, behind a start/done handshake.
//
// Ports:
//   clk          rising-edge system clock
//   reset_n      asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     WIDTH+1-bit unsigned dividend, captured on the accepting edge
//   divisor      2-bit unsigned divisor, captured on the accepting edge
//   busy         high while an operation is in progress (CALC or FINISH)
//   done         one-cycle pulse; quotient/remainder/div_by_zero are valid
//   quotient     registered WIDTH+1-bit quotient
//   remainder    registered 2-bit remainder
//   div_by_zero  registered flag for the last completed operation
module small_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH:0]   dividend,
  input  logic [1:0]       divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   quotient,
  output logic [1:0]       remainder,
  output logic             div_by_zero
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   dvd_sh;   // captured dividend, shifted left one bit per step
  logic [1:0]       dsr;      // captured divisor
  logic [1:0]       rem_acc;  // running partial remainder (always < divisor)
  logic [WIDTH-1:0] q_acc;    // quotient bits produced so far
  logic [CW-1:0]    cnt;      // steps remaining

  logic [2:0]       partial_c;
  logic             ge_c;
  logic [1:0]       rem_step_c;
  logic [WIDTH:0]   q_step_c;

  // One restoring step: bring down the next dividend bit and try a subtract.
  // When the subtract fails, partial < divisor <= 3, so its low two bits are
  // the whole value.
  always_comb begin
    partial_c  = {rem_acc, dvd_sh[WIDTH]};
    ge_c       = (partial_c >= {1'b0, dsr});
    rem_step_c = ge_c ? 2'(partial_c - {1'b0, dsr}) : partial_c[1:0];
    q_step_c   = {q_acc, ge_c};
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dvd_sh      <= '0;
      dsr         <= '0;
      rem_acc     <= '0;
      q_acc       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_sh  <= dividend;
            dsr     <= divisor;
            rem_acc <= '0;
            q_acc   <= '0;
            busy    <= 1'b1;
            if (divisor != 2'd0) begin
              cnt   <= CW'(DW);
              state <= CALC;
            end else begin
              // Division by zero completes immediately with a saturated quotient.
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= FINISH;
            end
          end
        end

        CALC: begin
          rem_acc <= rem_step_c;
          q_acc   <= q_step_c[WIDTH-1:0];
          dvd_sh  <= {dvd_sh[WIDTH-1:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient    <= q_step_c;
            remainder   <= rem_step_c;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_small_divider.sv
// tb_small_divider: scoreboard bench for small_divider. Stimulus pushes the
// expected result of each accepted operation; a monitor pops and compares on
// every done pulse.
module tb_small_divider;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [8:0] dividend;
  logic [1:0] divisor;
  logic       busy;
  logic       done;
  logic [8:0] quotient;
  logic [1:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [8:0] q;
    logic [1:0] r;
    logic       z;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  logic [8:0] last_q = '0;
  logic [1:0] last_r = '0;
  logic       last_z = 1'b0;
  logic       prev_done = 1'b0;

  small_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare each done pulse against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: q=%0d r=%0d z=%0b with no pending op at %0t",
                 quotient, remainder, div_by_zero, $time);
      end else begin
        e = exp_q.pop_front();
        chk("result_q", {23'd0, quotient}, {23'd0, e.q});
        chk("result_r", {30'd0, remainder}, {30'd0, e.r});
        chk("result_z", {31'd0, div_by_zero}, {31'd0, e.z});
      end
    end
    prev_done = done;
  end

  // Issue one operation, check busy, latency (edges after accept until done
  // is visible) and that results hold until done, then return once idle.
  task automatic run_op(input logic [8:0] a, input logic [1:0] b,
                        input logic [8:0] eq, input logic [1:0] er,
                        input logic ez, input int lat);
    int n;
    exp_t e;
    e.q = eq; e.r = er; e.z = ez;
    exp_q.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 9'($urandom); divisor = 2'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      chk("hold_results", {20'd0, quotient, remainder, div_by_zero},
          {20'd0, last_q, last_r, last_z});
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    last_q = eq; last_r = er; last_z = ez;
    @(posedge clk); #1;
    chk("idle_after_done", {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int d1;
    int d2;
    exp_t e;

    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {18'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_outputs", {18'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);

    run_op(9'd510, 2'd2, 9'd255, 2'd0, 1'b0, 9);
    run_op(9'd511, 2'd3, 9'd170, 2'd1, 1'b0, 9);
    run_op(9'd0,   2'd1, 9'd0,   2'd0, 1'b0, 9);
    run_op(9'd7,   2'd0, 9'h1FF, 2'd0, 1'b1, 0);
    run_op(9'd9,   2'd3, 9'd3,   2'd0, 1'b0, 9);

    // Start pulses during CALC (cycle 3) and FINISH (cycle 10) are ignored.
    e.q = 9'd250; e.r = 2'd0; e.z = 1'b0;
    exp_q.push_back(e);
    start = 1'b1; dividend = 9'd500; divisor = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    d1 = -1;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 3 || i == 10);
      if (start) begin dividend = 9'd9; divisor = 2'd3; end
      @(posedge clk); #1;
      if (done === 1'b1 && d1 < 0) d1 = i;
    end
    start = 1'b0;
    chk("ignored_done_at", 32'(d1), 32'd9);
    chk("ignored_no_restart", {31'd0, busy}, 32'd0);
    last_q = 9'd250; last_r = 2'd0; last_z = 1'b0;

    // Start held high: next accept only on the edge after FINISH.
    e.q = 9'd33; e.r = 2'd1; e.z = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    start = 1'b1; dividend = 9'd100; divisor = 2'd3;
    @(posedge clk); #1;
    d1 = -1; d2 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
      if (i == 10) chk("held_idle_gap", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    chk("held_first_done", 32'(d1), 32'd9);
    chk("held_second_done", 32'(d2), 32'd20);
    @(posedge clk); #1;
    last_q = 9'd33; last_r = 2'd1; last_z = 1'b0;

    // Reset mid-operation: immediate clear, no done afterwards.
    start = 1'b1; dividend = 9'd300; divisor = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_clear", {18'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    last_q = '0; last_r = '0; last_z = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_abort", {30'd0, done, busy}, 32'd0);
    run_op(9'd10, 2'd3, 9'd3, 2'd1, 1'b0, 9);

    // Exhaustive sweep over all dividends and nonzero divisors.
    for (int a = 0; a < 512; a++) begin
      for (int b = 1; b <= 3; b++) begin
        run_op(9'(a), 2'(b), 9'(a / b), 2'(a % b), 1'b0, 9);
      end
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
